// File: rtl/pulse_sequencer.sv
// Two-requester round-robin pulse sequencer: weighted-length pulse on `out`, then enforced gap.
// Optional PULSE_REPEAT_EN: auto owner re-fires the same pattern without a new ack while it holds its request.
module pulse_sequencer #(
    parameter int unsigned W1        = 131,
    parameter int unsigned W2        = 120,
    parameter int unsigned W3        = 87,
    parameter int unsigned W4        = 54,
    parameter int unsigned GAP_TICKS = 16,
    parameter int unsigned CNT_W     = 10
) (
    input  logic       sysclk,
    input  logic       rst,
    input  logic       tick,
    input  logic       req_man,
    input  logic [3:0] pat_man,
    input  logic       req_auto,
    input  logic [3:0] pat_auto,
    output logic       ack_man,
    output logic       ack_auto,
    output logic       out,
    output logic [3:0] pat_latch,
    output logic       owner,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_PULSE = 2'd2,
        ST_GAP   = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic               out_q, out_d;
    logic               ack_man_q, ack_man_d;
    logic               ack_auto_q, ack_auto_d;
    logic               done_q, done_d;
    logic               owner_q, owner_d;
    logic               busy_q, busy_d;
    logic               rr_q, rr_d;
    logic [3:0]         pat_q, pat_d;
    logic [CNT_W-1:0]   total_q, total_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               grant_en;
    logic               grant_auto;

    // Pulse length in ticks: sum of the weights of the set pattern bits.
    function automatic logic [CNT_W-1:0] pat_total(input logic [3:0] p);
        logic [CNT_W-1:0] s;
        s = '0;
        if (p[0]) s = s + CNT_W'(W1);
        if (p[1]) s = s + CNT_W'(W2);
        if (p[2]) s = s + CNT_W'(W3);
        if (p[3]) s = s + CNT_W'(W4);
        return s;
    endfunction

    always_ff @(posedge sysclk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            out_q      <= 1'b0;
            ack_man_q  <= 1'b0;
            ack_auto_q <= 1'b0;
            done_q     <= 1'b0;
            owner_q    <= 1'b0;
            busy_q     <= 1'b0;
            rr_q       <= 1'b0;
            pat_q      <= '0;
            total_q    <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            out_q      <= out_d;
            ack_man_q  <= ack_man_d;
            ack_auto_q <= ack_auto_d;
            done_q     <= done_d;
            owner_q    <= owner_d;
            busy_q     <= busy_d;
            rr_q       <= rr_d;
            pat_q      <= pat_d;
            total_q    <= total_d;
            count_q    <= count_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        out_d      = out_q;
        ack_man_d  = 1'b0;
        ack_auto_d = 1'b0;
        done_d     = 1'b0;
        owner_d    = owner_q;
        rr_d       = rr_q;
        pat_d      = pat_q;
        total_d    = total_q;
        count_d    = count_q;
        grant_en   = 1'b0;
        grant_auto = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // rr_q names the winner only on contention; a lone request leaves it alone.
                if (req_man && req_auto) begin
                    grant_en   = 1'b1;
                    grant_auto = rr_q;
                    rr_d       = ~rr_q;
                end else if (req_man) begin
                    grant_en   = 1'b1;
                end else if (req_auto) begin
                    grant_en   = 1'b1;
                    grant_auto = 1'b1;
                end
                if (grant_en) begin
                    ack_man_d  = ~grant_auto;
                    ack_auto_d = grant_auto;
                    owner_d    = grant_auto;
                    pat_d      = grant_auto ? pat_auto : pat_man;
                    total_d    = pat_total(pat_d);
                    state_d    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                count_d = '0;
                if (total_q == '0) begin
                    out_d   = 1'b0;
                    pat_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    out_d   = 1'b1;
                    state_d = ST_PULSE;
                end
            end
            ST_PULSE: begin
                if (tick) begin
                    if (count_q == total_q - CNT_W'(1)) begin
                        out_d   = 1'b0;
                        done_d  = 1'b1;
                        count_d = '0;
                        state_d = ST_GAP;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
            end
            ST_GAP: begin
                out_d = 1'b0;
                if (tick) begin
                    if (count_q == CNT_W'(GAP_TICKS - 1)) begin
                        count_d = '0;
`ifdef PULSE_REPEAT_EN
                        if (owner_q && req_auto && !req_man) begin
                            state_d = ST_LOAD;
                        end else begin
                            pat_d   = '0;
                            state_d = ST_IDLE;
                        end
`else
                        pat_d   = '0;
                        state_d = ST_IDLE;
`endif
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                out_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign ack_man   = ack_man_q;
    assign ack_auto  = ack_auto_q;
    assign out       = out_q;
    assign pat_latch = pat_q;
    assign owner     = owner_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_pulse_sequencer.sv
// Directed bench for pulse_sequencer: table of single grants plus arbitration, zero-pattern,
// reset-mid-pulse, late-request and (with PULSE_REPEAT_EN) auto-repeat sequences.
module tb_pulse_sequencer;

    localparam int unsigned GAP = 16;

    logic       sysclk = 1'b0;
    logic       rst, tick, req_man, req_auto;
    logic [3:0] pat_man, pat_auto;
    logic       ack_man, ack_auto, out, owner, busy, done;
    logic [3:0] pat_latch;

    always #5 sysclk = ~sysclk;

    pulse_sequencer dut (
        .sysclk    (sysclk),
        .rst       (rst),
        .tick      (tick),
        .req_man   (req_man),
        .pat_man   (pat_man),
        .req_auto  (req_auto),
        .pat_auto  (pat_auto),
        .ack_man   (ack_man),
        .ack_auto  (ack_auto),
        .out       (out),
        .pat_latch (pat_latch),
        .owner     (owner),
        .busy      (busy),
        .done      (done)
    );

    int   checks = 0;
    int   failures = 0;
    int   tick_period = 0;
    int   tick_div = 0;
    int   hi_cnt, done_cnt, gap_cnt, ackm_cnt, acka_cnt;
    bit   gap_active;
    logic prev_out = 1'b0;
    logic prev_busy = 1'b0;

    typedef struct {
        bit         src_auto;
        logic [3:0] pat;
        int         total;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic clr_mon();
        hi_cnt = 0; done_cnt = 0; gap_cnt = 0; ackm_cnt = 0; acka_cnt = 0;
        gap_active = 1'b0;
    endtask

    // One sysclk: tick driven on the falling edge, outputs observed 1 ns after the rising edge.
    task automatic step();
        @(negedge sysclk);
        tick = (tick_period > 0) && (tick_div == 0);
        tick_div = (tick_period > 0) ? (tick_div + 1) % tick_period : 0;
        @(posedge sysclk);
        #1;
        if (tick && prev_out) hi_cnt++;
        if (ack_man)  ackm_cnt++;
        if (ack_auto) acka_cnt++;
        if (done) begin
            done_cnt++;
            gap_active = 1'b1;
            gap_cnt = 0;
        end else if (gap_active) begin
            if (tick && prev_busy) gap_cnt++;
            if (!busy || out) gap_active = 1'b0;
        end
        prev_out  = out;
        prev_busy = busy;
    endtask

    task automatic wait_ack(input string nm, input int maxc, output bit got_auto);
        int n = 0;
        while (!(ack_man || ack_auto) && n < maxc) begin
            step();
            n++;
        end
        check({nm, " ack_seen"}, 32'(ack_man || ack_auto), 1);
        got_auto = ack_auto;
    endtask

    task automatic run_idle(input string nm, input int maxc, output int n);
        n = 0;
        while (busy && n < maxc) begin
            step();
            n++;
        end
        check({nm, " idle_reached"}, 32'(busy), 0);
    endtask

    task automatic serve(input string nm, input bit exp_auto, input logic [3:0] exp_pat,
                         input int exp_total, input bit drop);
        bit ga;
        int n;
        clr_mon();
        wait_ack(nm, 40, ga);
        check({nm, " ack_src"}, 32'(ga), 32'(exp_auto));
        check({nm, " owner"}, 32'(owner), 32'(exp_auto));
        check({nm, " pat_latch"}, 32'(pat_latch), 32'(exp_pat));
        if (drop) begin
            if (exp_auto) req_auto = 1'b0;
            else          req_man  = 1'b0;
        end
        step();
        check({nm, " out_rise"}, 32'(out), 32'(exp_total != 0));
        check({nm, " ack_one_cycle"}, 32'(ack_man || ack_auto), 0);
        run_idle(nm, 20000, n);
        if (exp_total == 0) check({nm, " zero_fast_idle"}, 32'(n <= 1), 1);
        check({nm, " high_ticks"}, 32'(hi_cnt), 32'(exp_total));
        check({nm, " done_count"}, 32'(done_cnt), 32'(exp_total != 0));
        check({nm, " gap_ticks"}, 32'(gap_cnt), (exp_total != 0) ? 32'(GAP) : 32'd0);
        check({nm, " ack_count"}, 32'(ackm_cnt + acka_cnt), 1);
        check({nm, " pat_cleared"}, 32'(pat_latch), 0);
    endtask

    initial begin
        int n;
        bit ga;
        rst = 1'b1; tick = 1'b0; req_man = 1'b0; req_auto = 1'b0;
        pat_man = '0; pat_auto = '0;

        vecs[0] = '{1'b0, 4'b0001, 131};
        vecs[1] = '{1'b1, 4'b0010, 120};
        vecs[2] = '{1'b0, 4'b1000, 54};
        vecs[3] = '{1'b1, 4'b0110, 207};
        vecs[4] = '{1'b0, 4'b0101, 218};
        vecs[5] = '{1'b1, 4'b0000, 0};

        // Reset state
        tick_period = 1;
        repeat (3) step();
        check("rst out", 32'(out), 0);
        check("rst busy", 32'(busy), 0);
        check("rst done", 32'(done), 0);
        check("rst ack_man", 32'(ack_man), 0);
        check("rst ack_auto", 32'(ack_auto), 0);
        check("rst owner", 32'(owner), 0);
        check("rst pat_latch", 32'(pat_latch), 0);
        rst = 1'b0;
        step();

        // Single-requester table
        for (int i = 0; i < 6; i++) begin
            tick_period = (i == 0) ? 8 : 3;
            tick_div = 0;
            if (vecs[i].src_auto) begin
                pat_auto = vecs[i].pat; req_auto = 1'b1;
            end else begin
                pat_man = vecs[i].pat; req_man = 1'b1;
            end
            serve($sformatf("vec%0d", i), vecs[i].src_auto, vecs[i].pat, vecs[i].total, 1'b1);
            step();
        end

        // Both held: manual, auto, manual
        tick_period = 2;
        pat_man = 4'b1111; pat_auto = 4'b0010;
        req_man = 1'b1; req_auto = 1'b1;
        serve("arb1", 1'b0, 4'b1111, 392, 1'b0);
        serve("arb2", 1'b1, 4'b0010, 120, 1'b0);
        serve("arb3", 1'b0, 4'b1111, 392, 1'b0);
        req_man = 1'b0; req_auto = 1'b0;
        step(); step();

        // Reset while pulsing at count 50 of 87
        clr_mon();
        pat_man = 4'b0100; req_man = 1'b1;
        wait_ack("rstmid", 40, ga);
        req_man = 1'b0;
        n = 0;
        while (hi_cnt < 50 && n < 1000) begin
            step();
            n++;
        end
        check("rstmid count50", 32'(hi_cnt), 50);
        check("rstmid out_before", 32'(out), 1);
        rst = 1'b1;
        step();
        check("rstmid out", 32'(out), 0);
        check("rstmid busy", 32'(busy), 0);
        check("rstmid pat_latch", 32'(pat_latch), 0);
        check("rstmid done", 32'(done), 0);
        rst = 1'b0;
        repeat (3) step();
        check("rstmid no_done", 32'(done_cnt), 0);
        req_man = 1'b1;
        serve("after_rst", 1'b0, 4'b0100, 87, 1'b1);
        step();

        // Manual request raised mid-pulse waits for IDLE
        clr_mon();
        pat_auto = 4'b1000; req_auto = 1'b1;
        wait_ack("late", 40, ga);
        req_auto = 1'b0;
        repeat (10) step();
        pat_man = 4'b0001; req_man = 1'b1;
        run_idle("late", 5000, n);
        check("late no_early_ack", 32'(ackm_cnt), 0);
        step();
        check("late ack_first_idle", 32'(ack_man), 1);
        check("late owner", 32'(owner), 0);
        check("late pat_latch", 32'(pat_latch), 32'(4'b0001));
        req_man = 1'b0;
        run_idle("late_done", 5000, n);
        step();

`ifdef PULSE_REPEAT_EN
        // Auto request held: pulse repeats with one ack; manual pre-empts at next IDLE
        clr_mon();
        pat_auto = 4'b1000; req_auto = 1'b1;
        n = 0;
        while (hi_cnt < 64 && n < 2000) begin
            step();
            n++;
        end
        check("rep second_pulse", 32'(hi_cnt), 64);
        check("rep gap", 32'(gap_cnt), 32'(GAP));
        check("rep done_once", 32'(done_cnt), 1);
        check("rep single_ack", 32'(acka_cnt), 1);
        check("rep pat_kept", 32'(pat_latch), 32'(4'b1000));
        pat_man = 4'b0001; req_man = 1'b1;
        n = 0;
        while (ackm_cnt == 0 && n < 2000) begin
            step();
            n++;
        end
        check("rep man_ack", 32'(ackm_cnt), 1);
        check("rep total_high", 32'(hi_cnt), 108);
        check("rep done_twice", 32'(done_cnt), 2);
        check("rep still_one_auto_ack", 32'(acka_cnt), 1);
        check("rep owner", 32'(owner), 0);
        req_man = 1'b0; req_auto = 1'b0;
        run_idle("rep_end", 5000, n);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
